// File: rtl/map_table_ckpt_if.sv
// rtl/map_table_ckpt_if.sv - dispatch, CDB, checkpoint control and lookup bundle for map_table_ckpt
interface map_table_ckpt_if #(
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 8,
  parameter int WIDTH    = 2,
  parameter int CDB_N    = 2,
  parameter int NUM_CKPT = 4
);
  localparam int REG_W  = $clog2(NUM_REGS);
  localparam int SLOT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CK_W   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

  logic [WIDTH*REG_W-1:0] disp_src_a;
  logic [WIDTH*REG_W-1:0] disp_src_b;
  logic [WIDTH*REG_W-1:0] disp_dest;
  logic [WIDTH*TAG_W-1:0] disp_tag;
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic [NUM_REGS-1:0]    clear_entries;
  logic                   ckpt_req;
  logic [SLOT_W-1:0]      ckpt_slot;
  logic                   ckpt_free;
  logic                   recover;
  logic [CK_W-1:0]        recover_id;
  logic [WIDTH*TAG_W-1:0] src_tag_a;
  logic [WIDTH*TAG_W-1:0] src_tag_b;
  logic [CK_W-1:0]        ckpt_id;
  logic                   ckpt_full;
  logic [CK_W:0]          ckpt_count;

  modport master (
    output disp_src_a, disp_src_b, disp_dest, disp_tag, cdb_tag, clear_entries,
           ckpt_req, ckpt_slot, ckpt_free, recover, recover_id,
    input  src_tag_a, src_tag_b, ckpt_id, ckpt_full, ckpt_count
  );

  modport slave (
    input  disp_src_a, disp_src_b, disp_dest, disp_tag, cdb_tag, clear_entries,
           ckpt_req, ckpt_slot, ckpt_free, recover, recover_id,
    output src_tag_a, src_tag_b, ckpt_id, ckpt_full, ckpt_count
  );
endinterface

// File: rtl/map_table_ckpt.sv
// rtl/map_table_ckpt.sv - register rename map table with CDB ready snooping and a circular FIFO of branch checkpoints
module map_table_ckpt #(
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 8,
  parameter int WIDTH    = 2,
  parameter int CDB_N    = 2,
  parameter int NUM_CKPT = 4
) (
  input  logic            clock,
  input  logic            reset,
  map_table_ckpt_if.slave bus
);
  localparam int REG_W = $clog2(NUM_REGS);
  localparam int CK_W  = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [REG_W-1:0] reg_t;
  typedef logic [CK_W-1:0]  ptr_t;
  typedef logic [CK_W:0]    cnt_t;

  localparam tag_t TAG_NULL = '1;
  localparam tag_t RDY_MASK = tag_t'(1) << (TAG_W - 2);
  localparam reg_t ZERO_REG = reg_t'(NUM_REGS - 1);
  localparam cnt_t CNT_MAX  = cnt_t'(NUM_CKPT);

  tag_t map_q    [NUM_REGS];
  tag_t map_d    [NUM_REGS];
  tag_t img      [NUM_REGS];
  tag_t rec_img  [NUM_REGS];
  tag_t ckpt_mem [NUM_CKPT][NUM_REGS];
  tag_t ckpt_d   [NUM_CKPT][NUM_REGS];

  ptr_t head_q, tail_q, head_d, tail_d;
  cnt_t count_q, count_d;
  logic full, free_ok, take;

  reg_t src_a [WIDTH];
  reg_t src_b [WIDTH];
  reg_t dest  [WIDTH];
  tag_t tag   [WIDTH];
  logic wr_en [WIDTH];

  // Retire clear wins over completion; null entries never pick up a ready flag.
  function automatic tag_t snoop(input tag_t t, input logic clr, input logic [CDB_N*TAG_W-1:0] cdb);
    tag_t r;
    r = t;
    if (clr || t == TAG_NULL) begin
      r = TAG_NULL;
    end else begin
      for (int c = 0; c < CDB_N; c++)
        if (cdb[c*TAG_W +: TAG_W] == t) r = t | RDY_MASK;
    end
    return r;
  endfunction

  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      src_a[k] = bus.disp_src_a[k*REG_W +: REG_W];
      src_b[k] = bus.disp_src_b[k*REG_W +: REG_W];
      dest[k]  = bus.disp_dest[k*REG_W +: REG_W];
      tag[k]   = bus.disp_tag[k*TAG_W +: TAG_W];
      wr_en[k] = (dest[k] != ZERO_REG) && (tag[k] != TAG_NULL);
    end
  end

  // Older slots in the same dispatch group bypass ahead of the table.
  always_comb begin
    tag_t ta, tb;
    bus.src_tag_a = '0;
    bus.src_tag_b = '0;
    for (int k = 0; k < WIDTH; k++) begin
      ta = map_q[src_a[k]];
      tb = map_q[src_b[k]];
      for (int j = 0; j < WIDTH; j++) begin
        if (j < k && wr_en[j]) begin
          if (dest[j] == src_a[k]) ta = tag[j];
          if (dest[j] == src_b[k]) tb = tag[j];
        end
      end
      if (src_a[k] == ZERO_REG || !reset) ta = TAG_NULL;
      if (src_b[k] == ZERO_REG || !reset) tb = TAG_NULL;
      bus.src_tag_a[k*TAG_W +: TAG_W] = ta;
      bus.src_tag_b[k*TAG_W +: TAG_W] = tb;
    end
  end

  // img is the table as seen by the branch in ckpt_slot: only slots up to and including it.
  always_comb begin
    for (int e = 0; e < NUM_REGS; e++) begin
      map_d[e] = snoop(map_q[e], bus.clear_entries[e], bus.cdb_tag);
      img[e]   = map_d[e];
      for (int j = 0; j < WIDTH; j++) begin
        if (wr_en[j] && dest[j] == reg_t'(e)) begin
          map_d[e] = tag[j] & ~RDY_MASK;
          if (j <= int'(bus.ckpt_slot)) img[e] = tag[j] & ~RDY_MASK;
        end
      end
      rec_img[e] = snoop(ckpt_mem[bus.recover_id][e], bus.clear_entries[e], bus.cdb_tag);
    end
  end

  always_comb begin
    full    = (count_q == CNT_MAX);
    free_ok = bus.ckpt_free && (count_q != '0);
    take    = bus.ckpt_req && !bus.recover && (!full || free_ok);
    head_d  = free_ok ? head_q + ptr_t'(1) : head_q;
    tail_d  = take ? tail_q + ptr_t'(1) : tail_q;
    count_d = count_q + cnt_t'(take) - cnt_t'(free_ok);
    if (bus.recover) begin
      // Restoring the checkpoint being freed leaves the FIFO empty at that slot.
      if (free_ok && bus.recover_id == head_q) head_d = head_q;
      tail_d  = bus.recover_id;
      count_d = {1'b0, ptr_t'(bus.recover_id - head_d)};
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CKPT; c++)
      for (int e = 0; e < NUM_REGS; e++)
        ckpt_d[c][e] = (take && tail_q == ptr_t'(c)) ? img[e]
                     : snoop(ckpt_mem[c][e], bus.clear_entries[e], bus.cdb_tag);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int e = 0; e < NUM_REGS; e++) map_q[e] <= TAG_NULL;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int e = 0; e < NUM_REGS; e++) map_q[e] <= bus.recover ? rec_img[e] : map_d[e];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CKPT; c++)
      for (int e = 0; e < NUM_REGS; e++)
        ckpt_mem[c][e] <= ckpt_d[c][e];
  end

  assign bus.ckpt_id    = tail_q;
  assign bus.ckpt_full  = full;
  assign bus.ckpt_count = count_q;
endmodule
